// File: rtl/dm.sv
// dm -- data memory stage for the single-cycle CPU.
//
// Takes the ALU result as a byte address and performs word, halfword and byte
// loads/stores against an internal word-organised, little-endian RAM. Loads
// are combinational and sign/zero-extended to 32 bits. Stores merge the
// addressed byte lanes into the current word on the rising clock edge.
//
// Optional feature macro: DM_MISALIGN_CHECK_EN
//   defined   : misaligned halfword/word accesses raise misalign, stores are
//               suppressed and loads return 0.
//   undefined : misalign is tied 0 and the low address bits are ignored for
//               halfword/word accesses (forced alignment).
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rstn     in   1   asynchronous active-low reset, clears the whole array
//   DMWr     in   1   store enable for this cycle
//   addr     in  32   byte address (upper bits beyond the array wrap)
//   din      in  32   store data
//   DMType   in   3   000 word, 001 half signed, 010 half unsigned,
//                     011 byte signed, 100 byte unsigned, others word
//   dout     out 32   extended load data
//   misalign out  1   access not naturally aligned (feature build only)

module dm #(
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        DMWr,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [2:0]  DMType,
    output logic [31:0] dout,
    output logic        misalign
);

    localparam logic [2:0] T_HS = 3'b001;
    localparam logic [2:0] T_HU = 3'b010;
    localparam logic [2:0] T_BS = 3'b011;
    localparam logic [2:0] T_BU = 3'b100;

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic          is_half;
    logic          is_byte;
    logic          is_word;
    logic          misalign_int;
    logic [3:0]    lane_en;
    logic [31:0]   lane_mask;
    logic [31:0]   wr_data;
    logic [31:0]   merged_word;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic          wr_en;

    // Address bits above the array are deliberately dropped (wrap-around).
    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    assign word_idx = addr[AW+1:2];
    assign rd_word  = mem_q[word_idx];

    assign is_half  = (DMType == T_HS) || (DMType == T_HU);
    assign is_byte  = (DMType == T_BS) || (DMType == T_BU);
    assign is_word  = !is_half && !is_byte;

`ifdef DM_MISALIGN_CHECK_EN
    assign misalign_int = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
    assign misalign_int = 1'b0;
`endif
    assign misalign = misalign_int;

    // Byte-lane enables and lane-replicated store data; the replication lets
    // one mask select the right lanes without a shifter.
    always_comb begin
        lane_en = 4'b1111;
        wr_data = din;
        if (is_half) begin
            lane_en = addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {din[15:0], din[15:0]};
        end else if (is_byte) begin
            lane_en = 4'b0001 << addr[1:0];
            wr_data = {4{din[7:0]}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign lane_mask[8*gi +: 8] = {8{lane_en[gi]}};
        end
    endgenerate

    assign merged_word = (rd_word & ~lane_mask) | (wr_data & lane_mask);
    assign wr_en       = DMWr && !misalign_int;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    // Load path: lane select then extension.
    assign half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (addr[1:0])
            2'b00:   byte_sel = rd_word[7:0];
            2'b01:   byte_sel = rd_word[15:8];
            2'b10:   byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
    end

    always_comb begin
        dout = rd_word;
        case (DMType)
            T_HS:    dout = {{16{half_sel[15]}}, half_sel};
            T_HU:    dout = {16'h0000, half_sel};
            T_BS:    dout = {{24{byte_sel[7]}}, byte_sel};
            T_BU:    dout = {24'h000000, byte_sel};
            default: dout = rd_word;
        endcase
        if (misalign_int) begin
            dout = '0;
        end
    end

endmodule

// File: tb/tb_dm.sv
module tb_dm;

    localparam int DEPTH = 128;

    logic        clk;
    logic        rstn;
    logic        DMWr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [2:0]  DMType;
    logic [31:0] dout;
    logic        misalign;

    int vectors;
    int miscompares;

    // Reference model: a flat byte array, little-endian.
    logic [7:0] mb [DEPTH*4];

    dm #(.DEPTH(DEPTH)) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .DMWr     (DMWr),
        .addr     (addr),
        .din      (din),
        .DMType   (DMType),
        .dout     (dout),
        .misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_mis(input logic [31:0] a, input logic [2:0] t);
`ifdef DM_MISALIGN_CHECK_EN
        logic half;
        logic word;
        half = (t == 3'd1) || (t == 3'd2);
        word = !(t >= 3'd1 && t <= 3'd4);
        return (half && a[0]) || (word && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int base_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH) * 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] t);
        int b;
        int hoff;
        logic [15:0] h;
        logic [7:0]  y;
        b = base_of(a);
        hoff = a[1] ? 2 : 0;
        h = {mb[b + hoff + 1], mb[b + hoff]};
        y = mb[b + int'(a % 4)];
        if (exp_mis(a, t)) return 32'h0;
        case (t)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0, h};
            3'd3:    return {{24{y[7]}}, y};
            3'd4:    return {24'h0, y};
            default: return {mb[b + 3], mb[b + 2], mb[b + 1], mb[b]};
        endcase
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        int b;
        int hoff;
        b = base_of(a);
        hoff = a[1] ? 2 : 0;
        if (!exp_mis(a, t)) begin
            if (t == 3'd1 || t == 3'd2) begin
                mb[b + hoff]     = d[7:0];
                mb[b + hoff + 1] = d[15:8];
            end else if (t == 3'd3 || t == 3'd4) begin
                mb[b + int'(a % 4)] = d[7:0];
            end else begin
                mb[b]     = d[7:0];
                mb[b + 1] = d[15:8];
                mb[b + 2] = d[23:16];
                mb[b + 3] = d[31:24];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h00;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, commit at posedge.
    task automatic step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] t);
        @(negedge clk);
        DMWr = wr; addr = a; din = d; DMType = t;
        #1;
        check($sformatf("dout a=%08h t=%0d wr=%0d", a, t, wr), dout, exp_load(a, t));
        check($sformatf("misalign a=%08h t=%0d", a, t), {31'b0, misalign}, {31'b0, exp_mis(a, t)});
        @(posedge clk);
        if (wr) model_store(a, d, t);
    endtask

    // Read-only cycle checked against a fixed value as well as the model.
    task automatic peek(input logic [31:0] a, input logic [2:0] t, input logic [31:0] k,
                        input string tag);
        @(negedge clk);
        DMWr = 1'b0; addr = a; din = 32'h0; DMType = t;
        #1;
        check(tag, dout, k);
        check({tag, "_model"}, dout, exp_load(a, t));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_clear();
        rstn = 1'b1; DMWr = 1'b0; addr = 32'h0; din = 32'h0; DMType = 3'd0;

        // Reset pulse before the first edge.
        #2 rstn = 1'b0;
        #1;
        check("rst_dout_0", dout, 32'h0);
        addr = 32'h1FC; #1;
        check("rst_dout_1fc", dout, 32'h0);
        addr = 32'h31; #1;
`ifdef DM_MISALIGN_CHECK_EN
        check("rst_misalign", {31'b0, misalign}, 32'h1);
`else
        check("rst_misalign", {31'b0, misalign}, 32'h0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        peek(32'h0, 3'd0, 32'h0, "post_rst_0");
        peek(32'h1FC, 3'd0, 32'h0, "post_rst_1fc");

        // Word then byte merge.
        step(1'b1, 32'h10, 32'h12345678, 3'd0);
        peek(32'h10, 3'd0, 32'h12345678, "word_ld");
        step(1'b1, 32'h11, 32'h000000AB, 3'd3);
        peek(32'h10, 3'd0, 32'h1234AB78, "byte_merge");
        peek(32'h11, 3'd3, 32'hFFFFFFAB, "byte_sext");
        peek(32'h11, 3'd4, 32'h000000AB, "byte_zext");

        // Upper halfword.
        step(1'b1, 32'h22, 32'hFFFF8001, 3'd1);
        peek(32'h20, 3'd0, 32'h80010000, "half_merge");
        peek(32'h22, 3'd1, 32'hFFFF8001, "half_sext");
        peek(32'h22, 3'd2, 32'h00008001, "half_zext");

        // Wrap-around and read-during-write.
        step(1'b1, 32'h0, 32'h11112222, 3'd0);
        @(negedge clk);
        DMWr = 1'b1; addr = 32'h200; din = 32'hCAFEF00D; DMType = 3'd0;
        #1;
        check("rdw_old", dout, 32'h11112222);
        @(posedge clk);
        model_store(32'h200, 32'hCAFEF00D, 3'd0);
        #1;
        check("rdw_new", dout, 32'hCAFEF00D);
        peek(32'h0, 3'd0, 32'hCAFEF00D, "wrap_ld");

        // Misaligned word store.
        step(1'b1, 32'h31, 32'hDEADBEEF, 3'd0);
`ifdef DM_MISALIGN_CHECK_EN
        peek(32'h30, 3'd0, 32'h0, "mis_word_unchanged");
        peek(32'h31, 3'd0, 32'h0, "mis_load_zero");
`else
        peek(32'h30, 3'd0, 32'hDEADBEEF, "forced_align_store");
        peek(32'h31, 3'd0, 32'hDEADBEEF, "forced_align_load");
`endif

        // Reset asserted mid-cycle with a store pending: store is lost.
        @(negedge clk);
        DMWr = 1'b1; addr = 32'h40; din = 32'h77777777; DMType = 3'd0;
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_dout", dout, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_dout", dout, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        DMWr = 1'b0;
        model_clear();
        peek(32'h40, 3'd0, 32'h0, "store_lost");
        peek(32'h10, 3'd0, 32'h0, "rst_cleared");

        // Randomized traffic, mostly inside a small window to force reuse.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ((i % 4) != 0) a = a & 32'h0000_03FF;
            step(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
        end

        // Final sweep of the whole array.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 32'(i * 4), 32'h0, 3'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
